tttg_cpu_player: RTL and testbench



---
 rtl/tttg_pkg.sv | 31 +++
 rtl/tttg_line_eval.sv | 28 ++
 rtl/tttg_cpu_player.sv | 157 +++++++++++++++
 tb/tb_tttg_cpu_player.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tttg_pkg.sv
// Shared types and constant tables for the tic-tac-toe CPU player.
package tttg_pkg;

  typedef logic [1:0] cell_t;

  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_P1    = 2'b01;
  localparam cell_t CELL_P2    = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StScanWin,
    StScanBlk,
    StPick,
    StDrive,
    StConfirm
  } state_e;

  // Zero-based cell indices of the eight winning lines.
  localparam logic [3:0] LINE_TBL [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  // Fallback order: centre, corners, then edges (zero-based).
  localparam logic [3:0] PREF_TBL [9] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

endpackage

// File: rtl/tttg_line_eval.sv
// Flags a line holding two of the given mark plus one empty cell, and where the gap is.
module tttg_line_eval
  import tttg_pkg::*;
(
  input  logic [1:0] cell_a,
  input  logic [1:0] cell_b,
  input  logic [1:0] cell_c,
  input  logic [1:0] mark,
  output logic       hit,
  output logic [1:0] offset
);

  always_comb begin
    hit    = 1'b0;
    offset = 2'd0;
    if (cell_a == mark && cell_b == mark && cell_c == CELL_EMPTY) begin
      hit    = 1'b1;
      offset = 2'd2;
    end else if (cell_a == mark && cell_c == mark && cell_b == CELL_EMPTY) begin
      hit    = 1'b1;
      offset = 2'd1;
    end else if (cell_b == mark && cell_c == mark && cell_a == CELL_EMPTY) begin
      hit    = 1'b1;
      offset = 2'd0;
    end
  end

endmodule

// File: rtl/tttg_cpu_player.sv
// Player-2 opponent: snapshots the board on its turn, scans for win/block/fallback,
// presses the chosen button and confirms the game core recorded the mark.
module tttg_cpu_player
  import tttg_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  input  logic [1:0] who,
  output logic       play2,
  output logic [8:0] button,
  output logic       busy,
  output logic [3:0] move_cell,
  output logic       move_err
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e            state;
  logic [8:0][1:0]   live;
  logic [8:0][1:0]   snap;
  logic [2:0]        line_cnt;
  logic [3:0]        target;
  logic [HW-1:0]     hold_cnt;
  logic [TW-1:0]     to_cnt;

  logic [3:0]        n_p1, n_p2;
  logic              any_empty, turn;
  logic              line_hit;
  logic [1:0]        line_off;
  logic [3:0]        hit_tgt, pick_idx, tgt_sel;
  logic              go_drive;

  assign live = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  always_comb begin
    n_p1      = 4'd0;
    n_p2      = 4'd0;
    any_empty = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (live[i] == CELL_P1) n_p1 = n_p1 + 4'd1;
      if (live[i] == CELL_P2) n_p2 = n_p2 + 4'd1;
      if (live[i] == CELL_EMPTY) any_empty = 1'b1;
    end
  end

  assign turn = enable && (who == 2'b00) && any_empty && (n_p1 == n_p2 + 4'd1);

  tttg_line_eval u_line_eval (
    .cell_a (snap[LINE_TBL[line_cnt][0]]),
    .cell_b (snap[LINE_TBL[line_cnt][1]]),
    .cell_c (snap[LINE_TBL[line_cnt][2]]),
    .mark   ((state == StScanWin) ? CELL_P2 : CELL_P1),
    .hit    (line_hit),
    .offset (line_off)
  );

  assign hit_tgt = LINE_TBL[line_cnt][line_off];

  // Walk the preference list backwards so the earliest empty entry wins.
  always_comb begin
    pick_idx = PREF_TBL[0];
    for (int i = 8; i >= 0; i--) begin
      if (snap[PREF_TBL[i]] == CELL_EMPTY) pick_idx = PREF_TBL[i];
    end
  end

  assign tgt_sel  = (state == StPick) ? pick_idx : hit_tgt;
  assign go_drive = (state == StPick) ||
                    (((state == StScanWin) || (state == StScanBlk)) && line_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      snap      <= '0;
      line_cnt  <= 3'd0;
      target    <= 4'd0;
      hold_cnt  <= '0;
      to_cnt    <= '0;
      play2     <= 1'b0;
      button    <= 9'd0;
      busy      <= 1'b0;
      move_cell <= 4'd0;
      move_err  <= 1'b0;
    end else begin
      move_err <= 1'b0;
      case (state)
        StIdle: begin
          if (turn) begin
            snap     <= live;
            line_cnt <= 3'd0;
            busy     <= 1'b1;
            state    <= StScanWin;
          end
        end
        StScanWin, StScanBlk, StPick: begin
          if (!enable) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else if (go_drive) begin
            target    <= tgt_sel;
            button    <= 9'd1 << tgt_sel;
            play2     <= 1'b1;
            move_cell <= tgt_sel + 4'd1;
            hold_cnt  <= HW'(1);
            state     <= StDrive;
          end else if (line_cnt == 3'd7) begin
            line_cnt <= 3'd0;
            state    <= (state == StScanWin) ? StScanBlk : StPick;
          end else begin
            line_cnt <= line_cnt + 3'd1;
          end
        end
        StDrive: begin
          if (hold_cnt == HW'(HOLD_CYCLES)) begin
            play2  <= 1'b0;
            button <= 9'd0;
            to_cnt <= TW'(1);
            state  <= StConfirm;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        StConfirm: begin
          if (live[target] == CELL_P2) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else if (live[target] == CELL_P1 || to_cnt == TW'(TIMEOUT)) begin
            move_err <= 1'b1;
            busy     <= 1'b0;
            state    <= StIdle;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tttg_cpu_player.sv
// Randomised and directed checks of the CPU player against a rule-level board model.
module tb_tttg_cpu_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] who;
  logic [1:0] brd [9];
  logic       play2, busy, move_err;
  logic [8:0] button;
  logic [3:0] move_cell;

  int passed = 0;
  int total  = 0;

  int lines [8][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{1, 4, 7},
                       '{2, 5, 8}, '{3, 6, 9}, '{1, 5, 9}, '{3, 5, 7}};
  int pref [9] = '{5, 1, 3, 7, 9, 2, 4, 6, 8};

  always #5 clk = ~clk;

  tttg_cpu_player dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pos1      (brd[0]),
    .pos2      (brd[1]),
    .pos3      (brd[2]),
    .pos4      (brd[3]),
    .pos5      (brd[4]),
    .pos6      (brd[5]),
    .pos7      (brd[6]),
    .pos8      (brd[7]),
    .pos9      (brd[8]),
    .who       (who),
    .play2     (play2),
    .button    (button),
    .busy      (busy),
    .move_cell (move_cell),
    .move_err  (move_err)
  );

  // Expected target cell (1-based) and cycles from T to first DRIVE cycle.
  function automatic void ref_move(output int tgt, output int lat);
    int marks [2];
    int base [2];
    int nm, ne, e, c;
    marks = '{2, 1};
    base  = '{2, 10};
    tgt = 0;
    lat = 0;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 8; k++) begin
        nm = 0; ne = 0; e = 0;
        for (int j = 0; j < 3; j++) begin
          c = lines[k][j];
          if (int'(brd[c-1]) == marks[m]) nm++;
          else if (brd[c-1] == 2'b00) begin ne++; e = c; end
        end
        if (nm == 2 && ne == 1) begin
          tgt = e;
          lat = base[m] + k;
          return;
        end
      end
    end
    for (int p = 0; p < 9; p++) begin
      if (brd[pref[p]-1] == 2'b00) begin
        tgt = pref[p];
        lat = 18;
        return;
      end
    end
  endfunction

  task automatic clear_board();
    for (int i = 0; i < 9; i++) brd[i] = 2'b00;
  endtask

  task automatic set_board(input logic [8:0] xm, input logic [8:0] om);
    for (int i = 0; i < 9; i++) brd[i] = xm[i] ? 2'b01 : (om[i] ? 2'b10 : 2'b00);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; who = 2'b00;
    clear_board();
    repeat (3) @(negedge clk);
    total++; if (play2 !== 1'b0) $display("FAIL reset play2: got %b want 0", play2); else passed++;
    total++; if (button !== 9'd0) $display("FAIL reset button: got %b want 0", button); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passed++;
    total++; if (move_cell !== 4'd0) $display("FAIL reset move_cell: got %0d want 0", move_cell);
    else passed++;
    total++; if (move_err !== 1'b0) $display("FAIL reset move_err: got %b want 0", move_err);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: game core records P2; mode 1: nothing recorded; mode 2: cell taken by P1.
  task automatic do_move(input int mode, input string tag);
    int tgt, lat, n, h, m;
    logic [8:0] exp_btn;
    ref_move(tgt, lat);
    exp_btn = 9'd1 << (tgt - 1);
    enable = 1'b1; who = 2'b00;
    n = 0;
    do begin @(negedge clk); n++; end while (play2 !== 1'b1 && n < 40);
    total++; if (n != lat) $display("FAIL %s latency: got %0d want %0d", tag, n, lat); else passed++;
    total++; if (button !== exp_btn) $display("FAIL %s button: got %b want %b", tag, button, exp_btn);
    else passed++;
    total++; if (move_cell !== 4'(tgt)) $display("FAIL %s move_cell: got %0d want %0d", tag,
      move_cell, tgt); else passed++;
    h = 0;
    while (play2 === 1'b1 && h < 10) begin h++; @(negedge clk); end
    total++; if (h != 2) $display("FAIL %s hold: got %0d want 2", tag, h); else passed++;
    total++; if (button !== 9'd0 || busy !== 1'b1)
      $display("FAIL %s confirm entry: got button %b busy %b want 0/1", tag, button, busy);
    else passed++;
    if (mode == 0) begin
      brd[tgt-1] = 2'b10;
      @(negedge clk);
      total++; if (busy !== 1'b0 || move_err !== 1'b0)
        $display("FAIL %s confirm ok: got busy %b err %b want 0/0", tag, busy, move_err);
      else passed++;
    end else begin
      if (mode == 2) brd[tgt-1] = 2'b01;
      m = 0;
      do begin @(negedge clk); m++; end while (move_err !== 1'b1 && m < 40);
      total++; if (m != ((mode == 1) ? 15 : 1))
        $display("FAIL %s err delay: got %0d want %0d", tag, m, (mode == 1) ? 15 : 1);
      else passed++;
      total++; if (busy !== 1'b0) $display("FAIL %s busy at err: got %b want 0", tag, busy);
      else passed++;
      clear_board();
      @(negedge clk);
      total++; if (move_err !== 1'b0) $display("FAIL %s err width: got %b want 0", tag, move_err);
      else passed++;
    end
    clear_board();
    @(negedge clk);
  endtask

  task automatic test_directed();
    set_board(9'b000000011, 9'b000010000);
    do_move(0, "block");
    set_board(9'b001000011, 9'b000011000);
    do_move(0, "win");
    set_board(9'b000000001, 9'b000000000);
    do_move(0, "pick");
  endtask

  task automatic test_errors();
    set_board(9'b000000011, 9'b000010000);
    do_move(1, "timeout");
    set_board(9'b001000011, 9'b000011000);
    do_move(2, "taken");
  endtask

  task automatic test_random();
    int n2, c;
    for (int it = 0; it < 12; it++) begin
      clear_board();
      n2 = $urandom_range(0, 3);
      for (int k = 0; k < 2 * n2 + 1; k++) begin
        do c = $urandom_range(0, 8); while (brd[c] != 2'b00);
        brd[c] = (k <= n2) ? 2'b01 : 2'b10;
      end
      do_move(0, "random");
    end
  endtask

  task automatic test_reset_drive();
    int n;
    set_board(9'b000000011, 9'b000010000);
    enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (play2 !== 1'b1 && n < 40);
    total++; if (play2 !== 1'b1) $display("FAIL rst_drive start: got %b want 1", play2);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (play2 !== 1'b0 || button !== 9'd0)
      $display("FAIL rst_drive outputs: got play2 %b button %b want 0/0", play2, button);
    else passed++;
    total++; if (busy !== 1'b0 || move_cell !== 4'd0)
      $display("FAIL rst_drive state: got busy %b move_cell %0d want 0/0", busy, move_cell);
    else passed++;
    enable = 1'b0;
    clear_board();
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_enable_drop();
    int seen;
    logic busy_mid;
    set_board(9'b000000001, 9'b000000000);
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (play2 === 1'b1) seen++;
    end
    busy_mid = busy;
    enable = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (play2 === 1'b1) seen++;
    end
    total++; if (busy_mid !== 1'b1) $display("FAIL en_drop scanning: got busy %b want 1", busy_mid);
    else passed++;
    total++; if (seen != 0) $display("FAIL en_drop play2: got %0d pulses want 0", seen);
    else passed++;
    total++; if (busy !== 1'b0) $display("FAIL en_drop idle: got busy %b want 0", busy);
    else passed++;
    clear_board();
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_no_turn();
    int sb, sp;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        set_board(9'b000000001, 9'b000000000);
        who = 2'b01;
      end else begin
        set_board(9'b101100011, 9'b010011100);
        who = 2'b00;
      end
      enable = 1'b1;
      sb = 0; sp = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (busy === 1'b1) sb++;
        if (play2 === 1'b1) sp++;
      end
      total++; if (sb != 0) $display("FAIL no_turn%0d busy: got %0d cycles want 0", s, sb);
      else passed++;
      total++; if (sp != 0) $display("FAIL no_turn%0d play2: got %0d cycles want 0", s, sp);
      else passed++;
    end
    who = 2'b00;
    clear_board();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_random();
    test_reset_drive();
    test_enable_drop();
    test_no_turn();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
